cell_memory_arbiter: RTL
========================

Name: cell_memory_arbiter

Overview:
Shares the single-port synchronous life-game cell RAM between three requesters: VGA display fetch (read-only), mouse/button cell editor (write) and the generation engine (read/write with lock for read-modify-write). Sits between vga_controller-driven fetch logic, the mouse/button edit path and the generation step logic inside life_game. Runs on clock_50mhz, issues at most one RAM access per cycle and returns read data with a fixed latency.

Parameters:
ADDR_WIDTH, 12, cell RAM word address width
DATA_WIDTH, 8, cell RAM word width (cells per word)
LOCK_MAX, 64, maximum cycles the engine may hold lock before it is ignored

Ports:
clock  in  1  system clock (clock_50mhz)
reset_n  in  1  asynchronous active-low reset
disp_req  in  1  display read request
disp_addr  in  ADDR_WIDTH  display read address
disp_gnt  out  1  display access issued (1-cycle pulse)
disp_rvalid  out  1  display read data valid on rdata
edit_req  in  1  editor write request
edit_addr  in  ADDR_WIDTH  editor write address
edit_wdata  in  DATA_WIDTH  editor write data
edit_gnt  out  1  editor write issued
eng_req  in  1  engine request
eng_we  in  1  engine write (1) / read (0)
eng_addr  in  ADDR_WIDTH  engine address
eng_wdata  in  DATA_WIDTH  engine write data
eng_lock  in  1  engine holds editor off for read-modify-write
eng_gnt  out  1  engine access issued
eng_rvalid  out  1  engine read data valid on rdata
rdata  out  DATA_WIDTH  read data, shared by display and engine
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en with mem_we=0
lock_timeout  out  1  sticky: lock exceeded LOCK_MAX

Behaviour:
- Reset (async, reset_n=0): all gnt, rvalid, mem_en, mem_we, lock_timeout = 0; mem_addr, mem_wdata, rdata = 0; state IDLE; lock counter 0; last_winner = editor; prev_granted = none. Any in-flight read is dropped; no rvalid after reset release.
- Arbitration on each posedge from sampled req inputs; result registered: gnt_x, mem_en, mem_we, mem_addr, mem_wdata driven in the following cycle. One grant per cycle, gnt pulse is exactly 1 cycle.
- Eligibility: port granted in the previous cycle is ineligible this edge (requester drops req on the edge it sees gnt; prevents double grant). Consequence: each port at most one access per 2 cycles.
- Priority: display strictly above others. Editor vs engine: round-robin, winner = port not equal to last_winner; last_winner updated only on editor/engine grants.
- Read latency: req sampled edge k -> gnt + mem_en during cycle k..k+1 -> rdata (registered copy of mem_rdata) and rvalid_x during cycle k+2..k+3. Writes produce no rvalid.
- Editor writes: mem_we=1, mem_wdata=edit_wdata. Engine: mem_we=eng_we.
- Lock FSM: IDLE -> LOCKED when eng_lock=1 and eng_gnt issued. In LOCKED editor ineligible; display still served. LOCKED -> IDLE when eng_lock=0. Counter counts LOCKED cycles; on reaching LOCK_MAX: lock_timeout=1 (sticky until reset), -> IDLE, eng_lock ignored until it deasserts.
- No requests: mem_en=0, mem_addr holds last value.
- Simultaneous display write impossible (read-only); display + read result of engine never share the same rdata cycle ambiguity since one grant per cycle.

Decomposition:
- Shared package: port index constants (PORT_DISPLAY=0, PORT_EDIT=1, PORT_ENGINE=2), lock FSM state encodings (IDLE, LOCKED).
- One sub-module natural: round_robin_2 (two-requester round-robin picker with last_winner register); display priority and lock FSM stay in the top of the block.

Test Plan:
- Reset release, eng_req=1 read addr 0x010, RAM[0x010]=0xA5 -> eng_gnt 1 cycle later, mem_addr=0x010, eng_rvalid with rdata=0xA5 two cycles after sampling.
- disp_req, edit_req, eng_req all held high 8 cycles -> grant order D, E(engine wins first since last_winner=editor), D, editor, D, engine...; never same port on consecutive cycles.
- Editor write 0x3C to 0x123, then display read 0x123 -> mem_we pulse with mem_wdata=0x3C; display rdata=0x3C.
- Engine lock with read 0x040, editor requesting continuously, then engine write 0x040, lock drop -> no edit_gnt during LOCKED, display still granted; edit_gnt within 2 cycles after lock drop.
- eng_lock held LOCK_MAX+5 cycles with edit_req high -> lock_timeout=1 at cycle LOCK_MAX, edit_gnt resumes; flag stays 1 until reset_n pulse.
- reset_n asserted in cycle between eng_gnt and eng_rvalid -> no eng_rvalid, all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/cell_memory_arbiter_pkg.sv
// Shared definitions for the cell RAM arbiter: requester port indices
// and the engine lock FSM state encoding.
package cell_memory_arbiter_pkg;

    localparam logic [1:0] PORT_DISPLAY = 2'd0;
    localparam logic [1:0] PORT_EDIT    = 2'd1;
    localparam logic [1:0] PORT_ENGINE  = 2'd2;
    localparam logic [1:0] PORT_NONE    = 2'd3;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/cell_memory_arbiter_round_robin_2.sv
// Round-robin picker between the editor and the engine.
// Ports: clock, reset_n; req_edit/req_eng in; pick_edit/pick_eng out.
// A pick is taken as a grant, so last_winner advances on every pick.
module cell_memory_arbiter_round_robin_2
    import cell_memory_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_edit,
    input  logic req_eng,
    output logic pick_edit,
    output logic pick_eng
);

    logic [1:0] last_winner;

    always_comb begin
        pick_edit = req_edit;
        pick_eng  = req_eng;
        if (req_edit && req_eng) begin
            pick_edit = (last_winner != PORT_EDIT);
            pick_eng  = (last_winner == PORT_EDIT);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_winner <= PORT_EDIT;
        end else if (pick_edit) begin
            last_winner <= PORT_EDIT;
        end else if (pick_eng) begin
            last_winner <= PORT_ENGINE;
        end
    end

endmodule

// File: rtl/cell_memory_arbiter.sv
// Single-port cell RAM arbiter: display reads, editor writes, engine r/w.
// Ports: clock, reset_n; disp_*/edit_*/eng_* requester sides with
// 1-cycle gnt pulses and rvalid; mem_* RAM side; shared rdata;
// lock_timeout sticky flag for an engine lock held too long.
module cell_memory_arbiter
    import cell_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,
    input  logic                  edit_req,
    input  logic [ADDR_WIDTH-1:0] edit_addr,
    input  logic [DATA_WIDTH-1:0] edit_wdata,
    output logic                  edit_gnt,
    input  logic                  eng_req,
    input  logic                  eng_we,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_wdata,
    input  logic                  eng_lock,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  lock_timeout
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    lock_state_t      lock_state;
    lock_state_t      lock_state_nx;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_ignore;
    logic             lock_expire;
    logic             edit_block;

    logic       disp_ok;
    logic       edit_ok;
    logic       eng_ok;
    logic       pick_edit;
    logic       pick_eng;
    logic [1:0] win_port;

    logic disp_pend;
    logic eng_pend;

    // The registered grant doubles as "granted last cycle".
    assign disp_ok = disp_req && !disp_gnt;
    assign edit_ok = edit_req && !edit_gnt && !edit_block;
    assign eng_ok  = eng_req && !eng_gnt;

    // Display wins outright, so the picker only sees the rest.
    cell_memory_arbiter_round_robin_2 u_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_edit  (edit_ok && !disp_ok),
        .req_eng   (eng_ok && !disp_ok),
        .pick_edit (pick_edit),
        .pick_eng  (pick_eng)
    );

    always_comb begin
        win_port = PORT_NONE;
        unique case (1'b1)
            disp_ok:   win_port = PORT_DISPLAY;
            pick_edit: win_port = PORT_EDIT;
            pick_eng:  win_port = PORT_ENGINE;
            default:   win_port = PORT_NONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_state <= LOCK_IDLE;
        end else begin
            lock_state <= lock_state_nx;
        end
    end

    always_comb begin
        lock_state_nx = lock_state;
        unique case (lock_state)
            LOCK_IDLE: begin
                if (win_port == PORT_ENGINE && eng_lock
                    && !lock_ignore) begin
                    lock_state_nx = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                if (!eng_lock || lock_expire) begin
                    lock_state_nx = LOCK_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        edit_block  = 1'b0;
        lock_expire = 1'b0;
        unique case (lock_state)
            LOCK_IDLE: begin
                edit_block = 1'b0;
            end
            LOCK_LOCKED: begin
                edit_block  = 1'b1;
                lock_expire = eng_lock && (lock_cnt == LOCK_LAST);
            end
        endcase
    end

    // lock_ignore keeps a timed-out lock from re-arming until the
    // engine actually lets go of eng_lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt     <= '0;
            lock_ignore  <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            if (lock_state == LOCK_LOCKED
                && lock_state_nx == LOCK_LOCKED) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end else begin
                lock_cnt <= '0;
            end
            if (lock_expire) begin
                lock_ignore  <= 1'b1;
                lock_timeout <= 1'b1;
            end else if (!eng_lock) begin
                lock_ignore <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_gnt  <= 1'b0;
            edit_gnt  <= 1'b0;
            eng_gnt   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            disp_gnt <= (win_port == PORT_DISPLAY);
            edit_gnt <= (win_port == PORT_EDIT);
            eng_gnt  <= (win_port == PORT_ENGINE);
            mem_en   <= (win_port != PORT_NONE);
            unique case (win_port)
                PORT_DISPLAY: begin
                    mem_we   <= 1'b0;
                    mem_addr <= disp_addr;
                end
                PORT_EDIT: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= edit_addr;
                    mem_wdata <= edit_wdata;
                end
                PORT_ENGINE: begin
                    mem_we    <= eng_we;
                    mem_addr  <= eng_addr;
                    mem_wdata <= eng_wdata;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // RAM data appears the cycle after the access; one more register
    // stage gives the fixed two-cycle read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_pend   <= 1'b0;
            eng_pend    <= 1'b0;
            disp_rvalid <= 1'b0;
            eng_rvalid  <= 1'b0;
            rdata       <= '0;
        end else begin
            disp_pend   <= disp_gnt;
            eng_pend    <= eng_gnt && !mem_we;
            disp_rvalid <= disp_pend;
            eng_rvalid  <= eng_pend;
            if (disp_pend || eng_pend) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
